// File: rtl/pipe_gap_gen.sv
// Pipe-gap height generator: holds top/bottom gap edges for N_PIPES slots and,
// on each Advance, shifts the slots left and appends a new height taken from a
// rotating table or from an LFSR reduced into [MIN_TOP, MAX_TOP].
module pipe_gap_gen #(
  parameter int          N_PIPES = 5,
  parameter int          W       = 10,
  parameter int          GAP     = 100,
  parameter int          MIN_TOP = 40,
  parameter int          MAX_TOP = 340,
  parameter logic [8*W-1:0] TABLE = {W'(230), W'(280), W'(150), W'(314),
                                     W'(110), W'(180), W'(252), W'(210)},
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Advance,
  input  logic               Mode,
  output logic [N_PIPES*W-1:0] YTop,
  output logic [N_PIPES*W-1:0] YBot,
  output logic               Busy,
  output logic               Updated,
  output logic               Overrun
);

  localparam int            RANGE    = MAX_TOP - MIN_TOP + 1;
  localparam logic [W:0]    RANGE_W  = (W+1)'(RANGE);
  localparam logic [W:0]    MIN_W    = (W+1)'(MIN_TOP);
  localparam logic [W-1:0]  GAP_T    = W'(GAP);
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]    TIX_RST  = 3'(N_PIPES % 8);

  typedef enum logic [1:0] {IDLE, GEN, LOAD} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [15:0]  lfsr;
  logic [2:0]   tix;
  logic         mode_r;
  logic         pend;
  logic [W:0]   cand;

  // One step of the 16-bit Galois LFSR (taps 16'hB400).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Bottom edge of a gap whose top edge is given.
  function automatic logic [W-1:0] bot_of(input logic [W-1:0] top);
    return top + GAP_T;
  endfunction

  // Table entry ix (entry 0 sits in the LSBs).
  function automatic logic [W-1:0] table_entry(input logic [2:0] ix);
    return TABLE[int'(ix)*W +: W];
  endfunction

  assign Busy = (state != IDLE);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: table mode spends one cycle in GEN, random mode stays until
  // the candidate has been reduced below the range size.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Advance || pend) state_nxt = GEN;
      GEN:     if (!mode_r || (cand < RANGE_W)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: LFSR, table index, mode latch, pending/overrun bookkeeping, Updated pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr    <= SEED_EFF;
      tix     <= TIX_RST;
      mode_r  <= 1'b0;
      pend    <= 1'b0;
      Overrun <= 1'b0;
      Updated <= 1'b0;
    end else begin
      lfsr    <= lfsr_step(lfsr);
      Updated <= (state == LOAD);
      case (state)
        IDLE: if (Advance || pend) begin
          mode_r <= Mode;
          // a fresh Advance arriving while a pending one is being started stays queued
          pend   <= pend && Advance;
        end
        LOAD: if (!mode_r) tix <= tix + 3'd1;
        default: ;
      endcase
      if (Busy && Advance) begin
        if (!pend) pend    <= 1'b1;
        else       Overrun <= 1'b1;
      end
    end
  end

  // Candidate height: latched on start, then reduced into range while in GEN.
  always_ff @(posedge Clk) begin
    if (state == IDLE && (Advance || pend)) begin
      cand <= Mode ? {1'b0, lfsr[W-1:0]} : {1'b0, table_entry(tix)};
    end else if (state == GEN && mode_r) begin
      if (cand >= RANGE_W) cand <= cand - RANGE_W;
      else                 cand <= cand + MIN_W;
    end
  end

  // Slot registers: reload from the table on reset, shift and append on LOAD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_PIPES; i++) begin
        YTop[i*W +: W] <= table_entry(3'(i));
        YBot[i*W +: W] <= bot_of(table_entry(3'(i)));
      end
    end else if (state == LOAD) begin
      for (int i = 0; i < N_PIPES-1; i++) begin
        YTop[i*W +: W] <= YTop[(i+1)*W +: W];
        YBot[i*W +: W] <= YBot[(i+1)*W +: W];
      end
      YTop[(N_PIPES-1)*W +: W] <= cand[W-1:0];
      YBot[(N_PIPES-1)*W +: W] <= bot_of(cand[W-1:0]);
    end
  end

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Directed bench for pipe_gap_gen with a scoreboard of expected new heights
// and their due cycles, plus a reference LFSR and slot model.
module tb_pipe_gap_gen;
  localparam int N = 5;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           adv;
  logic           mode;
  logic [N*W-1:0] ytop;
  logic [N*W-1:0] ybot;
  logic           busy;
  logic           upd;
  logic           ovr;

  pipe_gap_gen dut (
    .Clk(clk), .Reset(rst), .Advance(adv), .Mode(mode),
    .YTop(ytop), .YBot(ybot), .Busy(busy), .Updated(upd), .Overrun(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {int top; int due;} exp_t;

  int          tbl[8] = '{210, 252, 180, 110, 314, 150, 280, 230};
  int          mslot[N];
  int          mtix;
  logic [15:0] mlfsr;
  int          cyc = 0;
  exp_t        sb[$];
  int          npass = 0;
  int          ntotal = 0;
  int          nfail = 0;

  // Edge counter and reference LFSR.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) mlfsr <= 16'hACE1;
    else     mlfsr <= mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [N*W-1:0] model_bus(input bit bot);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(mslot[i] + (bot ? 100 : 0));
    return v;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) mslot[i] = tbl[i];
    mtix = N % 8;
    sb.delete();
  endtask

  task automatic push_table(input int k, input int off);
    sb.push_back('{tbl[mtix], k + off});
    mtix = (mtix + 1) % 8;
  endtask

  // One cycle: step to the falling edge and check whatever the DUT shows.
  task automatic tick();
    @(negedge clk);
    if (upd) begin
      if (sb.size() == 0) begin
        check("unexpected_updated", upd, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < N-1; i++) mslot[i] = mslot[i+1];
        mslot[N-1] = e.top;
        check("latency", cyc, e.due);
        check("new_top", ytop[(N-1)*W +: W], e.top);
        check("ytop", ytop, model_bus(0));
        check("ybot", ybot, model_bus(1));
        check("busy_at_update", busy, 0);
      end
    end else begin
      check("ytop_stable", ytop, model_bus(0));
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) check("settle_timeout", sb.size(), 0);
    tick();
  endtask

  initial begin
    int k;
    int cand;
    adv  = 1'b0;
    mode = 1'b0;
    rst  = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ytop", ytop, {10'd314, 10'd110, 10'd180, 10'd252, 10'd210});
    check("rst_ybot", ybot, {10'd414, 10'd210, 10'd280, 10'd352, 10'd310});
    check("rst_busy", busy, 0);
    check("rst_overrun", ovr, 0);
    check("rst_updated", upd, 0);
    rst = 1'b0;
    tick();

    // Table mode: first advance appends 150, then 280, 230, 210 (wrap), ...
    mode = 1'b0;
    k = cyc + 1;
    push_table(k, 2);
    adv = 1'b1;
    tick();
    adv = 1'b0;
    check("busy_after_advance", busy, 1);
    settle();
    for (int n = 0; n < 7; n++) begin
      k = cyc + 1;
      push_table(k, 2);
      adv = 1'b1;
      tick();
      adv = 1'b0;
      settle();
    end

    // Random mode against the reference LFSR.
    for (int n = 0; n < 1000; n++) begin
      mode = 1'b1;
      cand = int'(mlfsr[9:0]);
      k = cyc + 1;
      sb.push_back('{40 + cand % 301, k + 2 + cand / 301});
      adv = 1'b1;
      tick();
      adv = 1'b0;
      settle();
    end

    // Pending: two consecutive advances, both serviced three cycles apart.
    mode = 1'b0;
    k = cyc + 1;
    push_table(k, 2);
    push_table(k, 5);
    adv = 1'b1;
    tick();
    tick();
    adv = 1'b0;
    settle();
    check("pending_no_overrun", ovr, 0);

    // Overrun: three consecutive advances, the third is dropped.
    k = cyc + 1;
    push_table(k, 2);
    push_table(k, 5);
    adv = 1'b1;
    tick();
    tick();
    tick();
    adv = 1'b0;
    tick();
    check("overrun_set", ovr, 1);
    settle();
    check("overrun_sticky", ovr, 1);
    k = cyc + 1;
    push_table(k, 2);
    adv = 1'b1;
    tick();
    adv = 1'b0;
    settle();
    check("overrun_after_traffic", ovr, 1);

    // Reset in the middle of a random-mode generation.
    mode = 1'b1;
    adv  = 1'b1;
    tick();
    adv  = 1'b0;
    rst  = 1'b1;
    reset_model();
    tick();
    rst  = 1'b0;
    check("midrst_overrun", ovr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ytop", ytop, {10'd314, 10'd110, 10'd180, 10'd252, 10'd210});
    repeat (6) tick();

    // LFSR and table index restart from their reset values.
    mode = 1'b1;
    cand = int'(mlfsr[9:0]);
    k = cyc + 1;
    sb.push_back('{40 + cand % 301, k + 2 + cand / 301});
    adv = 1'b1;
    tick();
    adv = 1'b0;
    settle();
    mode = 1'b0;
    k = cyc + 1;
    push_table(k, 2);
    adv = 1'b1;
    tick();
    adv = 1'b0;
    settle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
